// File: rtl/cdb_arbiter_if.sv
// CDB result packet type and the arbiter bus: producer handshakes, flush, and the consumer-side broadcast.
// The master modport is the environment side and the slave modport is the arbiter side.
typedef struct packed {
    logic [5:0]  dest_ROB_entry;
    logic [31:0] result;
    logic        branch_result;
    logic        from_memory;
} CDB_packet_t;

interface cdb_arbiter_if #(
    parameter int NUM_FU = 4
);
    logic [NUM_FU-1:0] fu_valid;
    CDB_packet_t       fu_pkt [NUM_FU];
    logic [NUM_FU-1:0] fu_yumi;
    logic              flush;
    logic              cdb_ready;
    logic              cdb_valid;
    CDB_packet_t       cdb_out;
    logic [15:0]       grant_count;

    modport master (
        output fu_valid, fu_pkt, flush, cdb_ready,
        input  fu_yumi, cdb_valid, cdb_out, grant_count
    );

    modport slave (
        input  fu_valid, fu_pkt, flush, cdb_ready,
        output fu_yumi, cdb_valid, cdb_out, grant_count
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: grants one functional unit per cycle into a single broadcast register.
// Optional macro CDB_MEM_PRIORITY_EN lets the load unit (MEM_IDX) win without moving the pointer.
module cdb_arbiter #(
    parameter int NUM_FU  = 4,
    parameter int MEM_IDX = 3
) (
    input logic          clk,
    input logic          reset,
    cdb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_FU);

    if (NUM_FU < 2 || NUM_FU > 8) begin : g_bad_num_fu
        $error("NUM_FU must be in 2..8");
    end
    if (MEM_IDX < 0 || MEM_IDX >= NUM_FU) begin : g_bad_mem_idx
        $error("MEM_IDX must index a requester");
    end

    logic [PTR_W-1:0]  r_ptr;
    logic              r_cdb_valid;
    CDB_packet_t       r_cdb_out;
    logic [15:0]       r_grant_count;

    logic              w_can_grant;
    logic [NUM_FU-1:0] w_rot;
    logic              w_grant;
    logic [PTR_W:0]    w_sum;
    logic [PTR_W-1:0]  w_gidx;
    logic              w_upd_ptr;
    logic [PTR_W-1:0]  w_next_ptr;

    assign w_can_grant = ~bus.flush & ~reset & (~r_cdb_valid | bus.cdb_ready);

    // Rotate requests so bit k is the unit at offset k from the pointer.
    assign w_rot   = NUM_FU'({bus.fu_valid, bus.fu_valid} >> r_ptr);
    assign w_grant = w_can_grant & (|w_rot);

    always_comb begin
        w_sum     = '0;
        w_gidx    = '0;
        w_upd_ptr = 1'b1;
        // Descending scan: the smallest offset with a request is assigned last.
        for (int k = NUM_FU - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
            end
        end
        if (w_sum >= (PTR_W+1)'(NUM_FU)) begin
            w_sum = w_sum - (PTR_W+1)'(NUM_FU);
        end
        w_gidx = w_sum[PTR_W-1:0];
`ifdef CDB_MEM_PRIORITY_EN
        if (w_can_grant && bus.fu_valid[MEM_IDX]) begin
            w_gidx    = PTR_W'(MEM_IDX);
            w_upd_ptr = 1'b0;
        end
`endif
    end

    assign w_next_ptr = (w_gidx == PTR_W'(NUM_FU - 1)) ? '0 : w_gidx + 1'b1;

    assign bus.fu_yumi     = w_grant ? (NUM_FU'(1) << w_gidx) : '0;
    assign bus.cdb_valid   = r_cdb_valid;
    assign bus.cdb_out     = r_cdb_out;
    assign bus.grant_count = r_grant_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr         <= '0;
            r_cdb_valid   <= 1'b0;
            r_cdb_out     <= '0;
            r_grant_count <= '0;
        end else if (bus.flush) begin
            r_cdb_valid <= 1'b0;
        end else if (w_grant) begin
            r_cdb_out     <= bus.fu_pkt[w_gidx];
            r_cdb_valid   <= 1'b1;
            r_grant_count <= r_grant_count + 16'd1;
            if (w_upd_ptr) begin
                r_ptr <= w_next_ptr;
            end
        end else if (r_cdb_valid && bus.cdb_ready) begin
            r_cdb_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a driver computes expectations from a behavioural arbitration model,
// and a monitor compares per-cycle outputs and every consumed broadcast packet.
module tb_cdb_arbiter;
    localparam int N   = 4;
    localparam int MEM = 3;

    typedef struct {
        logic [N-1:0] yumi;
        bit           chk_state;
        bit           chk_out;
        logic         valid;
        CDB_packet_t  out;
        logic [15:0]  cnt;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_FU(N)) bus ();
    cdb_arbiter #(.NUM_FU(N), .MEM_IDX(MEM)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;

    exp_t        q_exp [$];
    CDB_packet_t q_pkt [$];

    logic [N-1:0] p_valid = '0;
    CDB_packet_t  p_pkt [N];

    int          m_ptr      = 0;
    bit          m_known    = 0;
    logic        m_valid    = 1'b0;
    CDB_packet_t m_out      = '0;
    bit          m_out_zero = 0;
    logic [15:0] m_cnt      = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic CDB_packet_t rand_pkt();
        CDB_packet_t p;
        p.dest_ROB_entry = 6'($urandom);
        p.result         = $urandom;
        p.branch_result  = 1'($urandom);
        p.from_memory    = 1'($urandom);
        return p;
    endfunction

    task automatic raise(input int i, input CDB_packet_t pkt);
        if (!p_valid[i]) begin
            p_valid[i] = 1'b1;
            p_pkt[i]   = pkt;
        end
    endtask

    // One cycle: drive inputs, predict the response, advance the model, then let producers see yumi.
    task automatic step(input bit rdy, input bit fl, input bit rst);
        exp_t e;
        int   g;
        bit   upd;
        bit   can;
        bus.fu_valid  = p_valid;
        for (int i = 0; i < N; i++) bus.fu_pkt[i] = p_pkt[i];
        bus.cdb_ready = rdy;
        bus.flush     = fl;
        reset         = rst;

        can = !fl && !rst && (!m_valid || rdy);
        g   = -1;
        upd = 1;
        if (can) begin
            for (int k = 0; k < N; k++)
                if (g < 0 && p_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
`ifdef CDB_MEM_PRIORITY_EN
            if (p_valid[MEM]) begin
                g   = MEM;
                upd = 0;
            end
`endif
        end

        e.yumi = '0;
        if (g >= 0) e.yumi[g] = 1'b1;
        e.chk_state = m_known;
        e.chk_out   = m_known && (m_valid || m_out_zero);
        e.valid     = m_valid;
        e.out       = m_out;
        e.cnt       = m_cnt;
        q_exp.push_back(e);

        if (rst) begin
            m_known    = 1;
            m_valid    = 1'b0;
            m_out      = '0;
            m_out_zero = 1;
            m_ptr      = 0;
            m_cnt      = '0;
            q_pkt.delete();
        end else if (fl) begin
            if (m_valid && q_pkt.size() > 0) void'(q_pkt.pop_front());
            m_valid = 1'b0;
        end else if (g >= 0) begin
            m_out      = p_pkt[g];
            m_valid    = 1'b1;
            m_out_zero = 0;
            m_cnt      = m_cnt + 16'd1;
            if (upd) m_ptr = (g + 1) % N;
            q_pkt.push_back(p_pkt[g]);
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end

        @(posedge clk);
        #1;
        if (g >= 0) p_valid[g] = 1'b0;
    endtask

    initial begin : monitor
        exp_t        e;
        CDB_packet_t p;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                check("fu_yumi", 64'(bus.fu_yumi), 64'(e.yumi));
                if (e.chk_state) begin
                    check("cdb_valid", 64'(bus.cdb_valid), 64'(e.valid));
                    check("grant_count", 64'(bus.grant_count), 64'(e.cnt));
                end
                if (e.chk_out) check("cdb_out", 64'(bus.cdb_out), 64'(e.out));
            end
            if (!reset && !bus.flush && bus.cdb_valid === 1'b1 && bus.cdb_ready === 1'b1) begin
                if (q_pkt.size() == 0) begin
                    check("pkt_underflow", 64'(1), 64'(0));
                end else begin
                    p = q_pkt.pop_front();
                    check("consumed_pkt", 64'(bus.cdb_out), 64'(p));
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        for (int i = 0; i < N; i++) p_pkt[i] = '0;
        bus.fu_valid  = '0;
        bus.flush     = 1'b0;
        bus.cdb_ready = 1'b0;
        for (int i = 0; i < N; i++) bus.fu_pkt[i] = '0;
        @(posedge clk);
        #1;

        step(0, 0, 1);
        step(0, 0, 1);

        // single requester, ROB 5 / result 7
        raise(0, '{dest_ROB_entry: 6'd5, result: 32'h0000_0007, branch_result: 1'b0, from_memory: 1'b0});
        step(1, 0, 0);
        step(1, 0, 0);

        // everyone requesting continuously
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) raise(i, rand_pkt());
            step(1, 0, 0);
        end
        repeat (6) step(1, 0, 0);

        // stall with units 1 and 2 waiting
        raise(0, rand_pkt());
        step(1, 0, 0);
        raise(1, rand_pkt());
        raise(2, rand_pkt());
        repeat (3) step(0, 0, 0);
        step(1, 0, 0);
        repeat (4) step(1, 0, 0);

        // flush colliding with a grant
        raise(2, rand_pkt());
        step(1, 1, 0);
        step(1, 0, 0);
        repeat (2) step(1, 0, 0);

        // wrap-around from the last unit
        raise(2, rand_pkt());
        step(1, 0, 0);
        step(1, 0, 0);
        raise(0, rand_pkt());
        raise(3, rand_pkt());
        repeat (3) step(1, 0, 0);

        // reset while a packet is stalled
        raise(1, rand_pkt());
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 1);
        step(1, 0, 0);
        repeat (2) step(1, 0, 0);

        // randomized traffic with varying request density
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (((c / 500) % 2) == 1) begin
                    if ($urandom_range(0, 3) == 0) raise(i, rand_pkt());
                end else begin
                    if ($urandom_range(0, 3) != 0) raise(i, rand_pkt());
                end
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates the Common Data Bus (CDB) among the execute-stage functional units (add/sub, multiply, load, and others). Each unit holds a `CDB_packet_t` result with valid high until it receives yumi. This block picks one producer per cycle by round-robin, acknowledges it, and registers the packet into a single broadcast register. That register drives the ROB and reservation stations, which may back-pressure it.

## Interface
Parameters:
- `NUM_FU`, default 4: number of requesting functional units, range 2..8.
- `MEM_IDX`, default 3: requester index of the load unit; used only under `CDB_MEM_PRIORITY_EN`.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `fu_valid` in `NUM_FU`: per-unit result pending; held until yumi.
- `fu_pkt` in `CDB_packet_t [NUM_FU]`: per-unit result packet; stable while valid.
- `fu_yumi` out `NUM_FU`: one-hot (or zero) acknowledge, combinational, same cycle as grant.
- `flush` in 1: mispredict recovery; kills the broadcast register and blocks grants this cycle.
- `cdb_ready` in 1: consumer accepts `cdb_out` this cycle.
- `cdb_valid` out 1: broadcast register holds a packet.
- `cdb_out` out `CDB_packet_t`: registered packet (`dest_ROB_entry`, `result`, `branch_result`, `from_memory`).
- `grant_count` out 16: number of grants since reset, wraps at 2^16.

## Operation
- **State:**
  - round-robin pointer `ptr` (`$clog2(NUM_FU)` bits)
  - broadcast register {`cdb_valid`, `cdb_out`}
  - `grant_count`
- **Slot free:** `can_grant = ~flush & ~reset & (~cdb_valid | cdb_ready)`.
- **Round-robin selection:**
  - Scan indices `ptr`, `ptr+1`, …, `ptr+NUM_FU-1` mod `NUM_FU`.
  - Grant the first index with `fu_valid` set, only if `can_grant`.
  - `fu_yumi[g]=1` for the winner; all other bits 0.
- **On grant g at posedge:**
  - `cdb_out <= fu_pkt[g]`; `cdb_valid <= 1`.
  - `ptr <= (g+1) mod NUM_FU`.
  - `grant_count <= grant_count+1`.
- **No grant, consumer drains** (`cdb_valid & cdb_ready`): `cdb_valid <= 0`; `cdb_out` is held (don't-care).
- **Stall** (`cdb_valid & ~cdb_ready`): register, `ptr` and `grant_count` are unchanged; all yumi are 0.
- **Flush:** `cdb_valid <= 0`; no yumi; `ptr` unchanged. Producers keep their valid; flushing them is the producers' responsibility.
- **No requesters:** `ptr` unchanged.
- **Wrap-around:** `ptr = NUM_FU-1` with a grant to `NUM_FU-1` sets `ptr` to 0.
- **Reset:**
  - `cdb_valid=0`, `cdb_out='0`, `ptr=0`, `grant_count=0`, `fu_yumi=0`.
  - Reset mid-stall drops the held packet.

## Timing
- **Grant latency:** producer valid in cycle N with the slot free gives `fu_yumi` in cycle N and `cdb_valid` from cycle N+1.
- **Producer side:** the producer clears its valid at the N+1 edge, as the add unit does.
- **Throughput:** one broadcast per cycle when `cdb_ready` is held high. Back-to-back grants are allowed because the register drains and refills on the same edge.
- **Fairness bound:** a continuously valid requester is granted within `NUM_FU` grants.
- **Yumi safety:** yumi never asserts in a cycle where the register cannot accept.
- **Priority of simultaneous events:** reset > flush > stall > grant.

## Configuration
- **Macro `CDB_MEM_PRIORITY_EN`:**
  - **Defined:** if `fu_valid[MEM_IDX]` and `can_grant`, `MEM_IDX` wins regardless of `ptr`, and `ptr` is not updated on that grant. Other grants use round-robin and update `ptr` as normal.
  - **Undefined:** `MEM_IDX` is ignored and pure round-robin applies.

## Test plan
- **Single requester:** reset, then `fu_valid=4'b0001`, `fu_pkt[0]={ROB 5, result 32'h0000_0007, br 0, mem 0}`, `cdb_ready=1`.
  - `fu_yumi=0001` same cycle.
  - Next cycle `cdb_valid=1`, `cdb_out.dest_ROB_entry=5`, `result=7`; `ptr=1`; `grant_count=1`.
- **All requesting:** `fu_valid=4'b1111` held for 8 cycles, `cdb_ready=1`.
  - Grant order 0,1,2,3,0,1,2,3 (with `CDB_MEM_PRIORITY_EN` undefined).
  - `grant_count=8`.
- **Stall:** `cdb_ready=0` for 3 cycles with `cdb_valid=1` and `fu_valid=4'b0110`.
  - `fu_yumi=0` throughout; `cdb_out` unchanged.
  - On `cdb_ready=1`, grant to unit 1 the same cycle.
- **Flush collides with grant:** `flush=1` while `fu_valid=4'b0100`.
  - `fu_yumi=0`; next cycle `cdb_valid=0`; `ptr` unchanged.
  - Cycle after flush deasserts: unit 2 granted.
- **Wrap and mem priority:** `ptr=3`, `fu_valid=4'b1001`.
  - Macro undefined: unit 3 granted, then unit 0, `ptr=1`.
  - Macro defined (`MEM_IDX=3`) with `ptr=0` and `fu_valid=4'b1001`: unit 3 granted first, `ptr` stays 0, then unit 0.
- **Reset mid-stall:** `cdb_valid=1`, `cdb_ready=0`, assert `reset` for 1 cycle.
  - Next cycle `cdb_valid=0`, `cdb_out=0`, `grant_count=0`, `ptr=0`, `fu_yumi=0` during reset.
